correlation_frame_loader: RTL

//   Upstream feeder for the 10-tap correlator. Accepts (x,h) 4-bit sample pairs one per handshake.

---
 rtl/corr_pkg.sv | 13 +
 rtl/corr_sample_fillbuf.sv | 80 ++++++++
 rtl/correlation_frame_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/corr_pkg.sv
// Shared constants and present-FSM encoding for the correlation frame loader.
package corr_pkg;

  localparam int unsigned DATA_W_DEF      = 4;
  localparam int unsigned N_TAPS          = 10;
  localparam int unsigned HOLD_CYCLES_DEF = 7;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } present_state_e;

endpackage

// File: rtl/corr_sample_fillbuf.sv
// Indexed 10-slot fill buffer: collects (x,h) pairs, flags FULL after the last slot,
// and holds FULL until the presenter takes the frame.
module corr_sample_fillbuf
  import corr_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_x,
  input  logic [DATA_W-1:0]            wr_h,
  input  logic                         take,
  output logic                         full,
  output logic                         ready,
  output logic [N_TAPS*2*DATA_W-1:0]   data
);

  localparam int unsigned IdxW = $clog2(N_TAPS);

  logic [IdxW-1:0]               idx_q, idx_d;
  logic                          full_q, full_d;
  logic                          ready_q, ready_d;
  logic                          accept;
  logic [N_TAPS-1:0][DATA_W-1:0] x_q, h_q;

  // Clear wins over a same-cycle transfer; a full buffer never accepts.
  assign accept = wr_en && !full_q && !clear;

  always_comb begin
    idx_d  = idx_q;
    full_d = full_q;
    if (clear) begin
      idx_d = '0;
    end else if (accept) begin
      if (idx_q == IdxW'(N_TAPS - 1)) begin
        idx_d  = '0;
        full_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (take) begin
      full_d = 1'b0;
    end
    // Stay low through the take edge so ready rises one edge after the swap.
    ready_d = !(full_q || full_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      x_q     <= '0;
      h_q     <= '0;
    end else begin
      idx_q   <= idx_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      if (accept) begin
        x_q[idx_q] <= wr_x;
        h_q[idx_q] <= wr_h;
      end
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      data[i*2*DATA_W +: DATA_W]          = x_q[i];
      data[i*2*DATA_W + DATA_W +: DATA_W] = h_q[i];
    end
  end

  assign full  = full_q;
  assign ready = ready_q;

endmodule

// File: rtl/correlation_frame_loader.sv
// Double-buffered frame loader: fills 10 (x,h) pairs, then presents all 20 values in
// parallel and holds them stable for HOLD_CYCLES cycles.
module correlation_frame_loader
  import corr_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_h,
  input  logic              clear,
  output logic [DATA_W-1:0] x_0,
  output logic [DATA_W-1:0] x_1,
  output logic [DATA_W-1:0] x_2,
  output logic [DATA_W-1:0] x_3,
  output logic [DATA_W-1:0] x_4,
  output logic [DATA_W-1:0] x_5,
  output logic [DATA_W-1:0] x_6,
  output logic [DATA_W-1:0] x_7,
  output logic [DATA_W-1:0] x_8,
  output logic [DATA_W-1:0] x_9,
  output logic [DATA_W-1:0] h_0,
  output logic [DATA_W-1:0] h_1,
  output logic [DATA_W-1:0] h_2,
  output logic [DATA_W-1:0] h_3,
  output logic [DATA_W-1:0] h_4,
  output logic [DATA_W-1:0] h_5,
  output logic [DATA_W-1:0] h_6,
  output logic [DATA_W-1:0] h_7,
  output logic [DATA_W-1:0] h_8,
  output logic [DATA_W-1:0] h_9,
  output logic              frame_start,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned CntW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned FrameW = N_TAPS * 2 * DATA_W;
  localparam int unsigned SlotW  = 2 * DATA_W;

  present_state_e    state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic [FrameW-1:0] fill_data;
  logic              fs_q, busy_q, busy_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              full, take;

  corr_sample_fillbuf #(
    .DATA_W (DATA_W)
  ) u_fillbuf (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .wr_en (in_valid && in_ready),
    .wr_x  (in_x),
    .wr_h  (in_h),
    .take  (take),
    .full  (full),
    .ready (in_ready),
    .data  (fill_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    fcnt_d  = fcnt_q;
    frame_d = frame_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: take = full;
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (full) begin
          take = 1'b1;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    // Swap: all 20 outputs load together, and only here.
    if (take) begin
      frame_d = fill_data;
      state_d = StHold;
      busy_d  = 1'b1;
      cnt_d   = CntW'(HOLD_CYCLES - 1);
      fcnt_d  = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      frame_q <= '0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      fs_q    <= take;
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign frame_cnt   = fcnt_q;

  assign x_0 = frame_q[0*SlotW +: DATA_W];
  assign x_1 = frame_q[1*SlotW +: DATA_W];
  assign x_2 = frame_q[2*SlotW +: DATA_W];
  assign x_3 = frame_q[3*SlotW +: DATA_W];
  assign x_4 = frame_q[4*SlotW +: DATA_W];
  assign x_5 = frame_q[5*SlotW +: DATA_W];
  assign x_6 = frame_q[6*SlotW +: DATA_W];
  assign x_7 = frame_q[7*SlotW +: DATA_W];
  assign x_8 = frame_q[8*SlotW +: DATA_W];
  assign x_9 = frame_q[9*SlotW +: DATA_W];
  assign h_0 = frame_q[0*SlotW + DATA_W +: DATA_W];
  assign h_1 = frame_q[1*SlotW + DATA_W +: DATA_W];
  assign h_2 = frame_q[2*SlotW + DATA_W +: DATA_W];
  assign h_3 = frame_q[3*SlotW + DATA_W +: DATA_W];
  assign h_4 = frame_q[4*SlotW + DATA_W +: DATA_W];
  assign h_5 = frame_q[5*SlotW + DATA_W +: DATA_W];
  assign h_6 = frame_q[6*SlotW + DATA_W +: DATA_W];
  assign h_7 = frame_q[7*SlotW + DATA_W +: DATA_W];
  assign h_8 = frame_q[8*SlotW + DATA_W +: DATA_W];
  assign h_9 = frame_q[9*SlotW + DATA_W +: DATA_W];

endmodule
